pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Converts the PLL `lock` indication into a clean, glitch-filtered system reset and ready flag for logic running on the 90 MHz PLL output clock. It sits directly downstream of the rPLL: the PLL's `clkout` drives `clk` and its `lock` drives `lock`. It releases `sys_rst_n` only after lock has been stable for a programmable settle time. It re-asserts `sys_rst_n` on a sustained loss of lock and keeps a saturating count of lock-loss events for debug.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `lock`; must be ≥2.
- `SETTLE_CYCLES`, 1024: consecutive synchronized-lock-high cycles required before release; must be ≥1.
- `DROP_FILTER`, 4: consecutive synchronized-lock-low cycles in RUN that count as a loss; must be ≥1.
- `HOLD_CYCLES`, 64: minimum cycles `sys_rst_n` is held low after a loss; must be ≥1.
- `CNT_W`, 8: width of `lost_cnt`.

- `clk`  in  1  PLL output clock (90 MHz); the single clock of the block.
- `rst_n`  in  1  asynchronous, active-low reset.
- `lock`  in  1  PLL lock, asynchronous to `clk`.
- `clr_lost`  in  1  synchronous pulse; clears `lost_cnt` and `lost_sticky`.
- `sys_rst_n`  out  1  active-low reset for downstream logic, registered.
- `ready`  out  1  high while in RUN, registered.
- `state`  out  2  FSM state: WAIT_LOCK=0, SETTLE=1, RUN=2, HOLD=3.
- `lost_cnt`  out  CNT_W  saturating count of lock-loss events.
- `lost_sticky`  out  1  set on any lock-loss event; cleared only by `clr_lost` or reset.

## Operation
- Synchronizer:
  - `lock` passes through a `SYNC_STAGES` flop chain; the chain output is `lock_s`.
  - `lock_s` equals `lock` delayed by `SYNC_STAGES` edges.
  - All flops in the chain reset to 0.
- WAIT_LOCK:
  - Settle and drop counters are held at 0.
  - On an edge where `lock_s`=1, the FSM moves to SETTLE.
- SETTLE:
  - The settle counter increments on each edge where `lock_s`=1.
  - On the edge where the counter equals `SETTLE_CYCLES`-1 and `lock_s`=1, the FSM moves to RUN.
  - Any `lock_s`=0 edge returns the FSM to WAIT_LOCK and clears the counter; it does not count as a loss event.
- RUN:
  - The drop counter counts consecutive `lock_s`=0 edges and clears on any `lock_s`=1 edge.
  - On the edge where the drop count would reach `DROP_FILTER`, the FSM moves to HOLD and a loss event is recorded.
  - A loss event increments `lost_cnt`, saturating at 2^CNT_W−1, and sets `lost_sticky`.
- HOLD:
  - The hold counter counts `HOLD_CYCLES` edges regardless of `lock_s`.
  - When it completes, the FSM moves to WAIT_LOCK.
- Outputs: `sys_rst_n` and `ready` are registered and both equal (next_state==RUN). They change on the same edge as `state`.
- `clr_lost`:
  - Takes effect on the next edge.
  - If a loss event occurs on the same edge, the event wins: `lost_cnt`=1 and `lost_sticky`=1.
- Counter widths: each counter is $clog2 of its limit, plus 1 bit. Counters never wrap.

## Timing
- Reset values, applied asynchronously while `rst_n`=0: `sys_rst_n`=0, `ready`=0, `state`=0, `lost_cnt`=0, `lost_sticky`=0; synchronizer and all counters 0.
- Reset removal: takes effect at the first `clk` edge after `rst_n` rises.
- Reset mid-operation, in any state: immediately forces the reset values. `lost_cnt` is lost.
- Release latency: with `lock` already high, or rising before edge 0, `sys_rst_n` rises at edge `SYNC_STAGES`+`SETTLE_CYCLES`.
- Loss latency: with `lock` falling before edge 0 while in RUN, `sys_rst_n` falls at edge `SYNC_STAGES`+`DROP_FILTER`−1.
- Minimum reset pulse on loss: `HOLD_CYCLES`+1+`SETTLE_CYCLES` cycles, counted when `lock` is already back high by the end of HOLD.
- Glitches: a `lock` low pulse of ≤`DROP_FILTER`−1 cycles in RUN has no effect on any output.

## Test plan
Use `SYNC_STAGES`=2, `SETTLE_CYCLES`=8, `DROP_FILTER`=3, `HOLD_CYCLES`=4, `CNT_W`=4.
- Power-up: hold `rst_n`=0, raise `rst_n` with `lock`=1 → `state` goes 0→1→2; `sys_rst_n` and `ready` rise exactly 10 edges after the first post-reset edge; `lost_cnt`=0.
- Settle abort: `lock` drops for 1 cycle at the 5th SETTLE cycle → FSM returns to WAIT_LOCK, release is delayed by the full re-settle, and `lost_cnt` stays 0.
- Glitch vs. loss in RUN:
  - A 2-cycle `lock` low leaves `sys_rst_n`=1.
  - A 3-cycle low gives `sys_rst_n`=0 at the 4th edge after `lock` falls, `state`=3, `lost_cnt`=1, `lost_sticky`=1.
  - After HOLD (4 cycles), with `lock` high, RUN is re-entered 8 cycles after WAIT_LOCK.
- Saturation: force 17 loss events → `lost_cnt`=15.
- Clear collision: assert `clr_lost` on the same edge as a loss event with `lost_cnt`=5 → `lost_cnt`=1, `lost_sticky`=1. `clr_lost` alone gives 0/0.
- Async reset in RUN: drop `rst_n` between edges → `sys_rst_n`, `ready`, `state`, `lost_cnt` and `lost_sticky` go to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Turns the asynchronous PLL lock indication into a clean, glitch-filtered
// active-low system reset and a ready flag. The block runs on the PLL output
// clock.
//
// Ports:
//   clk          PLL output clock, the only clock of the block
//   rst_n        asynchronous active-low reset
//   lock         PLL lock, asynchronous to clk
//   clr_lost     synchronous pulse, clears lost_cnt and lost_sticky
//   sys_rst_n    registered active-low reset for downstream logic
//   ready        registered, high while in RUN
//   state        FSM state (WAIT_LOCK=0, SETTLE=1, RUN=2, HOLD=3)
//   lost_cnt     saturating count of lock-loss events
//   lost_sticky  set on any lock-loss event
//
// Handshake: there is no valid/ready protocol here; clr_lost is a plain
// single-cycle request sampled on the next clock edge, and a loss event on
// that same edge takes priority over the clear.
module pll_lock_supervisor #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1024,
    parameter int DROP_FILTER   = 4,
    parameter int HOLD_CYCLES   = 64,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lock,
    input  logic             clr_lost,
    output logic             sys_rst_n,
    output logic             ready,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] lost_cnt,
    output logic             lost_sticky
);

    localparam int SW = $clog2(SETTLE_CYCLES) + 1;
    localparam int DW = $clog2(DROP_FILTER) + 1;
    localparam int HW = $clog2(HOLD_CYCLES) + 1;

    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [DW-1:0] DROP_LAST   = DW'(DROP_FILTER - 1);
    localparam logic [HW-1:0] HOLD_LAST   = HW'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2,
        HOLD      = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic              lock_s;
    logic [SW-1:0]     settle_q, settle_d;
    logic [DW-1:0]     drop_q, drop_d;
    logic [HW-1:0]     hold_q, hold_d;
    logic              loss;
    logic              out_q;
    logic [CNT_W-1:0]  lost_cnt_q;
    logic              lost_sticky_q;

    // Lock synchronizer; the oldest sample is the usable lock_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], lock};
        end
    end

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_LOCK;
            settle_q <= '0;
            drop_q   <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            drop_q   <= drop_d;
            hold_q   <= hold_d;
        end
    end

    // Each counter is only live in its own state and reads as zero elsewhere,
    // so every state entry starts from a clean count.
    always_comb begin
        state_d  = state_q;
        settle_d = '0;
        drop_d   = '0;
        hold_d   = '0;
        loss     = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) state_d = SETTLE;
            end
            SETTLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = RUN;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    if (drop_q == DROP_LAST) begin
                        state_d = HOLD;
                        loss    = 1'b1;
                    end else begin
                        drop_d = drop_q + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = WAIT_LOCK;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = WAIT_LOCK;
        endcase
    end

    // Outputs follow next_state so they change on the same edge as state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= 1'b0;
        end else begin
            out_q <= (state_d == RUN);
        end
    end

    // A loss on the same edge as a clear wins: the clear empties the count
    // and the new event is then recorded on top of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lost_cnt_q    <= '0;
            lost_sticky_q <= 1'b0;
        end else if (loss) begin
            lost_sticky_q <= 1'b1;
            if (clr_lost) begin
                lost_cnt_q <= CNT_W'(1);
            end else if (lost_cnt_q != {CNT_W{1'b1}}) begin
                lost_cnt_q <= lost_cnt_q + 1'b1;
            end
        end else if (clr_lost) begin
            lost_cnt_q    <= '0;
            lost_sticky_q <= 1'b0;
        end
    end

    assign sys_rst_n   = out_q;
    assign ready       = out_q;
    assign state       = state_q;
    assign lost_cnt    = lost_cnt_q;
    assign lost_sticky = lost_sticky_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with a run-length based reference
// model compared every cycle, plus literal latency/count expectations.
module tb_pll_lock_supervisor;

  localparam int SYNC   = 2;
  localparam int SETTLE = 8;
  localparam int DROP   = 3;
  localparam int HOLDC  = 4;
  localparam int CW     = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          lock = 1'b0;
  logic          clr_lost = 1'b0;
  logic          sys_rst_n;
  logic          ready;
  logic [1:0]    state;
  logic [CW-1:0] lost_cnt;
  logic          lost_sticky;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int base = 0;
  int mark = 0;

  pll_lock_supervisor #(
    .SYNC_STAGES(SYNC), .SETTLE_CYCLES(SETTLE), .DROP_FILTER(DROP),
    .HOLD_CYCLES(HOLDC), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .lock(lock), .clr_lost(clr_lost),
    .sys_rst_n(sys_rst_n), .ready(ready), .state(state),
    .lost_cnt(lost_cnt), .lost_sticky(lost_sticky)
  );

  // clock / reset block
  always #5 clk = ~clk;
  initial #1 rst_n = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: lock delayed by SYNC edges, then run-length rules
  logic exp_q[$];
  int   m_state, m_hi, m_lo, m_hold, m_cnt;
  logic m_sticky;

  always @(posedge clk or negedge rst_n) begin
    logic ls, ev;
    if (!rst_n) begin
      exp_q = {};
      for (int i = 0; i < SYNC; i++) exp_q.push_back(1'b0);
      m_state = 0; m_hi = 0; m_lo = 0; m_hold = 0; m_cnt = 0; m_sticky = 1'b0;
    end else begin
      ls = exp_q.pop_front();
      exp_q.push_back(lock);
      ev = 1'b0;
      if (m_state == 0) begin
        if (ls) begin m_state = 1; m_hi = 0; end
      end else if (m_state == 1) begin
        if (!ls) m_state = 0;
        else begin
          m_hi++;
          if (m_hi == SETTLE) begin m_state = 2; m_lo = 0; end
        end
      end else if (m_state == 2) begin
        if (ls) m_lo = 0;
        else begin
          m_lo++;
          if (m_lo == DROP) begin m_state = 3; m_hold = 0; ev = 1'b1; end
        end
      end else begin
        m_hold++;
        if (m_hold == HOLDC) m_state = 0;
      end
      if (ev) begin
        m_sticky = 1'b1;
        m_cnt = clr_lost ? 1 : ((m_cnt + 1 > 15) ? 15 : m_cnt + 1);
      end else if (clr_lost) begin
        m_cnt = 0; m_sticky = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    check("cyc_state", int'(state), m_state);
    check("cyc_sys_rst_n", int'(sys_rst_n), int'(m_state == 2));
    check("cyc_ready", int'(ready), int'(m_state == 2));
    check("cyc_lost_cnt", int'(lost_cnt), m_cnt);
    check("cyc_lost_sticky", int'(lost_sticky), int'(m_sticky));
  end

  // driver tasks: inputs change 2 time units after the active edge
  task automatic drive(input logic l, input logic c, input int n);
    for (int i = 0; i < n; i++) begin
      lock = l;
      clr_lost = c;
      @(posedge clk);
      #2;
    end
    clr_lost = 1'b0;
  endtask

  task automatic wait_for(input logic v);
    for (int i = 0; i < 200; i++) begin
      if (sys_rst_n == v) return;
      drive(lock, 1'b0, 1);
    end
    check("wait_timeout", int'(sys_rst_n), int'(v));
  endtask

  // edge index of the most recent edge, edge 0 being the first after base
  function automatic int edge_idx();
    return cyc - base - 1;
  endfunction

  task automatic do_reset(input logic l);
    rst_n = 1'b0;
    drive(l, 1'b0, 2);
    rst_n = 1'b1;
    base = cyc;
  endtask

  task automatic lose_recover();
    lock = 1'b0;
    wait_for(1'b0);
    lock = 1'b1;
    wait_for(1'b1);
  endtask

  initial begin
    @(posedge clk); #2;

    // power-up
    rst_n = 1'b0;
    lock = 1'b1;
    drive(1'b1, 1'b0, 2);
    check("rst_sys_rst_n", int'(sys_rst_n), 0);
    check("rst_state", int'(state), 0);
    check("rst_lost_cnt", int'(lost_cnt), 0);
    rst_n = 1'b1;
    base = cyc;
    drive(1'b1, 1'b0, 3);
    check("pwr_state_settle", int'(state), 1);
    wait_for(1'b1);
    check("pwr_release_edge", edge_idx(), 10);
    check("pwr_state_run", int'(state), 2);
    check("pwr_ready", int'(ready), 1);
    check("pwr_lost_cnt", int'(lost_cnt), 0);

    // settle abort: lock low for edge 6 only
    do_reset(1'b1);
    drive(1'b1, 1'b0, 6);
    drive(1'b0, 1'b0, 1);
    drive(1'b1, 1'b0, 2);
    check("abort_state_wait", int'(state), 0);
    wait_for(1'b1);
    check("abort_release_edge", edge_idx(), 17);
    check("abort_lost_cnt", int'(lost_cnt), 0);

    // 2-cycle glitch in RUN
    drive(1'b0, 1'b0, 2);
    drive(1'b1, 1'b0, 6);
    check("glitch_sys_rst_n", int'(sys_rst_n), 1);
    check("glitch_lost_cnt", int'(lost_cnt), 0);

    // real loss, then recovery
    lock = 1'b0;
    base = cyc;
    wait_for(1'b0);
    check("loss_edge", edge_idx(), 4);
    check("loss_state", int'(state), 3);
    check("loss_lost_cnt", int'(lost_cnt), 1);
    check("loss_sticky", int'(lost_sticky), 1);
    mark = cyc;
    lock = 1'b1;
    wait_for(1'b1);
    check("recover_pulse", cyc - mark, HOLDC + 1 + SETTLE);

    // saturation
    do_reset(1'b1);
    wait_for(1'b1);
    for (int k = 0; k < 17; k++) lose_recover();
    check("sat_lost_cnt", int'(lost_cnt), 15);
    check("sat_sticky", int'(lost_sticky), 1);

    // clear collides with a loss event
    do_reset(1'b1);
    wait_for(1'b1);
    for (int k = 0; k < 5; k++) lose_recover();
    check("pre_clr_cnt", int'(lost_cnt), 5);
    drive(1'b0, 1'b0, 4);
    drive(1'b0, 1'b1, 1);
    check("coll_state", int'(state), 3);
    check("coll_lost_cnt", int'(lost_cnt), 1);
    check("coll_sticky", int'(lost_sticky), 1);
    drive(1'b1, 1'b1, 1);
    check("clr_lost_cnt", int'(lost_cnt), 0);
    check("clr_sticky", int'(lost_sticky), 0);
    wait_for(1'b1);

    // asynchronous reset while in RUN
    lose_recover();
    check("pre_async_cnt", int'(lost_cnt), 1);
    check("pre_async_state", int'(state), 2);
    rst_n = 1'b0;
    #1;
    check("async_sys_rst_n", int'(sys_rst_n), 0);
    check("async_ready", int'(ready), 0);
    check("async_state", int'(state), 0);
    check("async_lost_cnt", int'(lost_cnt), 0);
    check("async_sticky", int'(lost_sticky), 0);
    @(posedge clk); #2;
    drive(1'b1, 1'b0, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
